cache_stats_monitor: RTL and testbench
======================================

// Module: cache_stats_monitor
// PURPOSE
//  Synthesizable, multi-channel successor to bench-side hit/miss tallying. Watches busy/hit_miss of up to
//  NUM_CHANNELS cache instances, classifies every completed access (hit/miss, read/write) into per-channel
//  saturating counters, and serves counters through a registered read port. Sits beside the caches; no feedback into them.
// PARAMETERS
//  NUM_CHANNELS  2   number of monitored caches (1..8)
//  COUNT_WIDTH   32  width of every statistic counter (8..64)
// PORTS
//  clk           in   1                  single clock, all logic on posedge
//  rst_n         in   1                  asynchronous, active-low reset
//  busy_in       in   NUM_CHANNELS       per-channel cache busy; falling edge = access complete
//  hit_miss_in   in   NUM_CHANNELS       1=hit, 0=miss; sampled in the cycle busy_in is first seen low
//  read_in       in   NUM_CHANNELS       access type, sampled on busy rise
//  write_in      in   NUM_CHANNELS       access type, sampled on busy rise
//  freeze_in     in   1                  1 = suppress all counting (FSMs still track)
//  clear_req_in  in   1                  request zeroing of all counters
//  clear_ack_out out  1                  one-cycle pulse when clear has been applied
//  rd_en_in      in   1                  read request
//  rd_chan_in    in   $clog2(NUM_CHANNELS) channel select (min width 1)
//  rd_sel_in     in   3                  counter select (stats_sel_t)
//  rd_valid_out  out  1                  pulse, 1 cycle after rd_en_in
//  rd_data_out   out  COUNT_WIDTH        selected counter value
//  rd_err_out    out  1                  with rd_valid_out: illegal chan/sel, rd_data_out=0
// BEHAVIOUR
//  - Reset: all counters 0, clear_ack_out=0, rd_valid_out=0, rd_data_out=0, rd_err_out=0, every FSM in SYNC.
//  - Per-channel FSM: SYNC -> IDLE when busy_in=0 (a transaction in flight at reset release is never counted);
//    IDLE -> BUSY on busy_in=1, latching read_in/write_in; BUSY -> IDLE on busy_in=0, emitting one completion event.
//  - Completion event (unless freeze_in=1): HITS or MISSES +1 per hit_miss_in; READS +1 if latched read, WRITES +1
//    if latched write (both if both set, neither if neither). Counters saturate at all-ones, never wrap.
//  - Counters per channel (stats_sel_t): 0 HITS, 1 MISSES, 2 READS, 3 WRITES, 4 BUSY_CYCLES, 5 MAX_MISS_LAT; 6,7 illegal.
//  - Clear: clear_req_in=1 sampled -> next cycle all counters zeroed and clear_ack_out=1 for one cycle. A completion
//    event in the same cycle as the clear is applied after zeroing (affected counter reads 1). clear_req_in held
//    high re-clears every cycle; ack pulses every cycle it is held.
//  - Read port: registered, latency 1; rd_data_out reflects counter state at the rd_en_in edge (pre-update).
//    rd_valid_out=0 -> rd_data_out holds last value. Back-to-back reads every cycle supported.
//  - Channels >= NUM_CHANNELS or sel 6/7 (4/5 when macro absent) -> rd_err_out=1, rd_data_out=0.
// CONFIGURATION
//  CACHE_STATS_LATENCY_EN defined: per-channel cycle counter runs in BUSY; BUSY_CYCLES accumulates cycles spent
//    in BUSY (saturating, subject to freeze_in/clear); MAX_MISS_LAT keeps max busy length of any miss.
//  Undefined: no latency logic generated; sel 4/5 are illegal reads.
// STRUCTURE
//  Package cache_stats_pkg: stats_sel_t enum, STATS_NUM_SEL constant, sat_inc function (saturating +1).
//  Sub-module cache_stats_channel: one FSM plus its counter bank; instantiated NUM_CHANNELS times by generate.
//  Top holds clear/ack logic and the registered read mux.
// TESTING
//  1 reset release with busy_in[0]=1, then fall -> SYNC swallows it, HITS[0]=MISSES[0]=0.
//  2 ch0: 3 read hits, 2 write misses -> HITS=3, MISSES=2, READS=3, WRITES=2; ch1 all 0.
//  3 COUNT_WIDTH=8, 300 hits on ch1 -> HITS[1]=255, no wrap.
//  4 clear_req_in in same cycle as ch0 miss completion -> ack 1 cycle later, MISSES[0]=1, others 0.
//  5 rd_chan=3 with NUM_CHANNELS=2, and rd_sel=7 -> rd_valid=1, rd_err=1, rd_data=0.
//  6 macro on: misses with busy lengths 4, 9, 6 cycles -> BUSY_CYCLES=19, MAX_MISS_LAT=9; freeze_in=1 on a 3rd -> unchanged.

Source files
------------

// File: rtl/cache_stats_pkg.sv
// Shared types and helpers for the cache statistics monitor.
// Optional latency statistics are enabled with CACHE_STATS_LATENCY_EN.
package cache_stats_pkg;

  typedef enum logic [2:0] {
    SEL_HITS         = 3'd0,
    SEL_MISSES       = 3'd1,
    SEL_READS        = 3'd2,
    SEL_WRITES       = 3'd3,
    SEL_BUSY_CYCLES  = 3'd4,
    SEL_MAX_MISS_LAT = 3'd5
  } stats_sel_t;

  localparam int unsigned STATS_NUM_SEL = 6;

  typedef enum logic [1:0] {
    CH_SYNC = 2'd0,
    CH_IDLE = 2'd1,
    CH_BUSY = 2'd2
  } chan_state_t;

  // Saturating +1 on the low `width` bits of a 64-bit carrier.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/cache_stats_monitor_channel.sv
// Legacy-named wrapper is not needed; see cache_stats_channel in this file.
// Per-channel access tracker and counter bank (latency stats under CACHE_STATS_LATENCY_EN).
module cache_stats_channel
  import cache_stats_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic hit_miss,
  input  logic read,
  input  logic write,
  input  logic freeze,
  input  logic clear,
  output logic [STATS_NUM_SEL-1:0][COUNT_WIDTH-1:0] counters
);

  chan_state_t state, state_next;
  logic start, done;
  logic rd_lat, wr_lat;
  logic [COUNT_WIDTH-1:0] hits, misses, reads, writes;

  // Clear zeroes first; a same-cycle event then lands on the zeroed value.
  function automatic logic [COUNT_WIDTH-1:0] bump(input logic [COUNT_WIDTH-1:0] cur,
                                                  input logic en, input logic clr,
                                                  input logic frz);
    logic [COUNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    return (en && !frz) ? COUNT_WIDTH'(sat_inc(64'(base), COUNT_WIDTH)) : base;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CH_SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    unique case (state)
      CH_SYNC: if (!busy) state_next = CH_IDLE;
      CH_IDLE: if (busy) begin
        state_next = CH_BUSY;
        start      = 1'b1;
      end
      CH_BUSY: if (!busy) begin
        state_next = CH_IDLE;
        done       = 1'b1;
      end
      default: state_next = CH_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lat <= 1'b0;
      wr_lat <= 1'b0;
    end else if (start) begin
      rd_lat <= read;
      wr_lat <= write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits   <= '0;
      misses <= '0;
      reads  <= '0;
      writes <= '0;
    end else begin
      hits   <= bump(hits,   done &&  hit_miss, clear, freeze);
      misses <= bump(misses, done && !hit_miss, clear, freeze);
      reads  <= bump(reads,  done &&  rd_lat,   clear, freeze);
      writes <= bump(writes, done &&  wr_lat,   clear, freeze);
    end
  end

  assign counters[SEL_HITS]   = hits;
  assign counters[SEL_MISSES] = misses;
  assign counters[SEL_READS]  = reads;
  assign counters[SEL_WRITES] = writes;

`ifdef CACHE_STATS_LATENCY_EN
  logic [COUNT_WIDTH-1:0] lat_cnt, miss_len, busy_cycles, max_miss_lat, max_base, max_next;

  // lat_cnt counts BUSY cycles before the current one, so +1 gives the full length.
  assign miss_len = COUNT_WIDTH'(sat_inc(64'(lat_cnt), COUNT_WIDTH));

  always_comb begin
    max_base = clear ? '0 : max_miss_lat;
    max_next = max_base;
    if (done && !hit_miss && !freeze && (miss_len > max_base)) max_next = miss_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt      <= '0;
      busy_cycles  <= '0;
      max_miss_lat <= '0;
    end else begin
      if (start)                  lat_cnt <= '0;
      else if (state == CH_BUSY)  lat_cnt <= miss_len;
      busy_cycles  <= bump(busy_cycles, state == CH_BUSY, clear, freeze);
      max_miss_lat <= max_next;
    end
  end

  assign counters[SEL_BUSY_CYCLES]  = busy_cycles;
  assign counters[SEL_MAX_MISS_LAT] = max_miss_lat;
`else
  assign counters[SEL_BUSY_CYCLES]  = '0;
  assign counters[SEL_MAX_MISS_LAT] = '0;
`endif

endmodule

// File: rtl/cache_stats_monitor.sv
// Multi-channel cache hit/miss statistics with clear handshake and registered read port.
// Define CACHE_STATS_LATENCY_EN to enable BUSY_CYCLES / MAX_MISS_LAT counters.
module cache_stats_monitor
  import cache_stats_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] busy_in,
  input  logic [NUM_CHANNELS-1:0] hit_miss_in,
  input  logic [NUM_CHANNELS-1:0] read_in,
  input  logic [NUM_CHANNELS-1:0] write_in,
  input  logic                    freeze_in,
  input  logic                    clear_req_in,
  output logic                    clear_ack_out,
  input  logic                    rd_en_in,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] rd_chan_in,
  input  logic [2:0]              rd_sel_in,
  output logic                    rd_valid_out,
  output logic [COUNT_WIDTH-1:0]  rd_data_out,
  output logic                    rd_err_out
);

`ifdef CACHE_STATS_LATENCY_EN
  localparam int unsigned NUM_LEGAL_SEL = STATS_NUM_SEL;
`else
  localparam int unsigned NUM_LEGAL_SEL = 4;
`endif

  logic [STATS_NUM_SEL-1:0][COUNT_WIDTH-1:0] bank [NUM_CHANNELS];
  logic rd_legal;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    cache_stats_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .busy     (busy_in[g]),
      .hit_miss (hit_miss_in[g]),
      .read     (read_in[g]),
      .write    (write_in[g]),
      .freeze   (freeze_in),
      .clear    (clear_req_in),
      .counters (bank[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clear_ack_out <= 1'b0;
    else        clear_ack_out <= clear_req_in;
  end

  assign rd_legal = (32'(rd_chan_in) < NUM_CHANNELS) && (32'(rd_sel_in) < NUM_LEGAL_SEL);

  // Bank is sampled before this edge's updates land, giving pre-update read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_out <= 1'b0;
      rd_data_out  <= '0;
      rd_err_out   <= 1'b0;
    end else begin
      rd_valid_out <= rd_en_in;
      if (rd_en_in) begin
        if (rd_legal) begin
          rd_data_out <= bank[rd_chan_in][rd_sel_in];
          rd_err_out  <= 1'b0;
        end else begin
          rd_data_out <= '0;
          rd_err_out  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_stats_monitor.sv
// Self-checking bench for cache_stats_monitor (3 channels, 8-bit counters).
`timescale 1ns/1ps
module tb_cache_stats_monitor;
  import cache_stats_pkg::*;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] busy_in, hit_miss_in, read_in, write_in;
  logic           freeze_in, clear_req_in, clear_ack_out;
  logic           rd_en_in;
  logic [1:0]     rd_chan_in;
  logic [2:0]     rd_sel_in;
  logic           rd_valid_out;
  logic [CW-1:0]  rd_data_out;
  logic           rd_err_out;

  cache_stats_monitor #(.NUM_CHANNELS(NCH), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .busy_in(busy_in), .hit_miss_in(hit_miss_in),
    .read_in(read_in), .write_in(write_in), .freeze_in(freeze_in),
    .clear_req_in(clear_req_in), .clear_ack_out(clear_ack_out),
    .rd_en_in(rd_en_in), .rd_chan_in(rd_chan_in), .rd_sel_in(rd_sel_in),
    .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out), .rd_err_out(rd_err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [CW-1:0] data;
    logic          err;
    string         name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string         name;
    logic [1:0]    chan;
    logic [2:0]    sel;
    logic [CW-1:0] data;
    logic          err;
  } rd_vec_t;
  rd_vec_t vec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rd_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got 1 expected 0");
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, 32'(rd_data_out), 32'(e.data));
        check({e.name, "_err"},  32'(rd_err_out),  32'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input string name, input logic [1:0] ch, input logic [2:0] sel,
                            input logic [CW-1:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.name = name;
    rd_en_in   = 1'b1;
    rd_chan_in = ch;
    rd_sel_in  = sel;
    sb.push_back(x);
    step();
  endtask

  task automatic read_one(input string name, input logic [1:0] ch, input logic [2:0] sel,
                          input logic [CW-1:0] d);
    issue_read(name, ch, sel, d, 1'b0);
    rd_en_in = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  // busy high for len sampled cycles; completion edge optionally carries a clear request.
  task automatic access(input int unsigned ch, input logic rd, input logic wr,
                        input logic hit, input int unsigned len, input logic clr);
    busy_in[ch] = 1'b1; read_in[ch] = rd; write_in[ch] = wr; hit_miss_in[ch] = ~hit;
    repeat (len) step();
    busy_in[ch] = 1'b0; hit_miss_in[ch] = hit; read_in[ch] = 1'b0; write_in[ch] = 1'b0;
    clear_req_in = clr;
    step();
    clear_req_in = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    busy_in = 3'b001; hit_miss_in = '0; read_in = '0; write_in = '0;
    freeze_in = 1'b0; clear_req_in = 1'b0; rd_en_in = 1'b0; rd_chan_in = '0; rd_sel_in = '0;
    repeat (3) step();
    check("rst_ack",      32'(clear_ack_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid_out),  32'd0);
    check("rst_rd_data",  32'(rd_data_out),   32'd0);
    check("rst_rd_err",   32'(rd_err_out),    32'd0);

    // In-flight access across reset release must not be counted.
    rst_n = 1'b1;
    repeat (3) step();
    busy_in[0] = 1'b0; hit_miss_in[0] = 1'b1;
    repeat (2) step();
    read_one("sync_hits0",   2'd0, SEL_HITS,   8'd0);
    read_one("sync_misses0", 2'd0, SEL_MISSES, 8'd0);
    drain();

    for (int i = 0; i < 3; i++) access(0, 1'b1, 1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 2; i++) access(0, 1'b0, 1'b1, 1'b0, 3, 1'b0);

    vec.push_back('{"t2_hits1",   2'd1, SEL_HITS,   8'd0, 1'b0});
    vec.push_back('{"t2_misses1", 2'd1, SEL_MISSES, 8'd0, 1'b0});
    vec.push_back('{"t2_reads1",  2'd1, SEL_READS,  8'd0, 1'b0});
    vec.push_back('{"t2_writes1", 2'd1, SEL_WRITES, 8'd0, 1'b0});
    vec.push_back('{"t2_hits2",   2'd2, SEL_HITS,   8'd0, 1'b0});
    vec.push_back('{"err_chan3",  2'd3, SEL_HITS,   8'd0, 1'b1});
    vec.push_back('{"err_sel7",   2'd0, 3'd7,       8'd0, 1'b1});
    vec.push_back('{"err_sel6",   2'd0, 3'd6,       8'd0, 1'b1});
`ifdef CACHE_STATS_LATENCY_EN
    vec.push_back('{"t2_busy0",   2'd0, SEL_BUSY_CYCLES,  8'd12, 1'b0});
    vec.push_back('{"t2_maxlat0", 2'd0, SEL_MAX_MISS_LAT, 8'd3,  1'b0});
`else
    vec.push_back('{"err_sel4",   2'd0, SEL_BUSY_CYCLES,  8'd0, 1'b1});
    vec.push_back('{"err_sel5",   2'd0, SEL_MAX_MISS_LAT, 8'd0, 1'b1});
`endif
    vec.push_back('{"t2_misses0", 2'd0, SEL_MISSES, 8'd2, 1'b0});
    vec.push_back('{"t2_reads0",  2'd0, SEL_READS,  8'd3, 1'b0});
    vec.push_back('{"t2_writes0", 2'd0, SEL_WRITES, 8'd2, 1'b0});
    vec.push_back('{"t2_hits0",   2'd0, SEL_HITS,   8'd3, 1'b0});

    foreach (vec[i]) issue_read(vec[i].name, vec[i].chan, vec[i].sel, vec[i].data, vec[i].err);
    rd_en_in = 1'b0;
    step();
    check("idle_rd_valid", 32'(rd_valid_out), 32'd0);
    check("hold_rd_data",  32'(rd_data_out),  32'(vec[vec.size()-1].data));
    drain();

    // Saturation at 8 bits.
    for (int i = 0; i < 300; i++) access(1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    read_one("sat_hits1",   2'd1, SEL_HITS,   8'd255);
    read_one("sat_reads1",  2'd1, SEL_READS,  8'd255);
    read_one("sat_misses1", 2'd1, SEL_MISSES, 8'd0);
    read_one("sat_hits0",   2'd0, SEL_HITS,   8'd3);
    drain();

    // Clear coinciding with a ch0 miss completion.
    access(0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    check("clr_ack_pulse", 32'(clear_ack_out), 32'd1);
    step();
    check("clr_ack_drop",  32'(clear_ack_out), 32'd0);
    read_one("clr_misses0", 2'd0, SEL_MISSES, 8'd1);
    read_one("clr_hits0",   2'd0, SEL_HITS,   8'd0);
    read_one("clr_writes0", 2'd0, SEL_WRITES, 8'd0);
    read_one("clr_hits1",   2'd1, SEL_HITS,   8'd0);
`ifdef CACHE_STATS_LATENCY_EN
    read_one("clr_busy0",   2'd0, SEL_BUSY_CYCLES,  8'd1);
    read_one("clr_maxlat0", 2'd0, SEL_MAX_MISS_LAT, 8'd2);
`endif
    drain();

    // Held clear acks every cycle.
    clear_req_in = 1'b1;
    step();
    check("hold_ack1", 32'(clear_ack_out), 32'd1);
    step();
    check("hold_ack2", 32'(clear_ack_out), 32'd1);
    clear_req_in = 1'b0;
    step();
    check("hold_ack_drop", 32'(clear_ack_out), 32'd0);

    access(1, 1'b1, 1'b0, 1'b0, 4, 1'b0);
    access(1, 1'b1, 1'b0, 1'b0, 9, 1'b0);
    access(1, 1'b1, 1'b0, 1'b0, 6, 1'b0);
    freeze_in = 1'b1;
    access(1, 1'b1, 1'b0, 1'b0, 12, 1'b0);
    freeze_in = 1'b0;
    read_one("frz_misses1", 2'd1, SEL_MISSES, 8'd3);
    read_one("frz_reads1",  2'd1, SEL_READS,  8'd3);
    read_one("frz_misses0", 2'd0, SEL_MISSES, 8'd0);
`ifdef CACHE_STATS_LATENCY_EN
    read_one("lat_busy1",   2'd1, SEL_BUSY_CYCLES,  8'd19);
    read_one("lat_maxlat1", 2'd1, SEL_MAX_MISS_LAT, 8'd9);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
